// File: rtl/mdu_sequencer_pkg.sv
// Shared definitions for the multiply/divide unit.
// The opcode encoding matches the decoder's encoding, so the two must stay in lockstep.
// The default cycle counts live here so that the top module and any wrappers agree on them.
package mdu_sequencer_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MSUB  = 4'd10
  } mdu_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_t;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  // Opcodes that occupy the unit for a countdown and commit HI/LO at its end.
  function automatic logic is_multi(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) ||
           (op == OP_DIVU) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_sequencer_arith.sv
// Combinational HI/LO result generator for the latched MDU operation.
// Signed division is done on magnitudes and then sign-corrected, which gives truncation toward zero.
// div_by_zero tells the sequencer to leave HI/LO alone; hilo_nxt is meaningless in that case.
module mdu_sequencer_arith
  import mdu_sequencer_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] hilo_nxt,
  output logic        div_by_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [63:0] acc;
  logic        sdiv;
  logic [31:0] dvd;
  logic [31:0] dvs;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
  assign prod_u = {32'd0, rs} * {32'd0, rt};
  assign acc    = {hi, lo};

  // Magnitude division with sign fix-up: quotient negative when signs differ, remainder follows dividend.
  always_comb begin
    sdiv  = (op == OP_DIV);
    dvd   = (sdiv && rs[31]) ? -rs : rs;
    dvs   = (sdiv && rt[31]) ? -rt : rt;
    q_mag = dvd / dvs;
    r_mag = dvd % dvs;
    quot  = (sdiv && (rs[31] ^ rt[31])) ? -q_mag : q_mag;
    rem   = (sdiv && rs[31]) ? -r_mag : r_mag;
  end

  // Select the new {HI,LO}; accumulate forms use the HI/LO value present at commit time.
  always_comb begin
    hilo_nxt    = acc;
    div_by_zero = is_div(op) && (rt == 32'd0);
    case (op)
      OP_MULT:  hilo_nxt = prod_s;
      OP_MULTU: hilo_nxt = prod_u;
      OP_MADD:  hilo_nxt = acc + prod_s;
      OP_MSUB:  hilo_nxt = acc - prod_s;
      OP_DIV,
      OP_DIVU:  hilo_nxt = {rem, quot};
      default:  hilo_nxt = acc;
    endcase
  end

endmodule

// File: rtl/mdu_sequencer.sv
// E-stage multiply/divide sequencer: owns HI/LO, runs a busy countdown, raises the D-stage stall.
// Busy is high for exactly MULT_CYCLES or DIV_CYCLES cycles after the start cycle; HI/LO commit on the edge busy falls.
// Starts while running are dropped; stall_req keeps MDU users in D until the unit is idle.
module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_mdu_use,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] rd_data,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  mdu_state_t  state;
  mdu_state_t  state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  op_q;
  logic [31:0] rs_q;
  logic [31:0] rt_q;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        launch;
  logic        commit;
  logic [63:0] hilo_nxt;
  logic        div_by_zero;

  assign launch = (state == ST_IDLE) && start && is_multi(mdu_op);
  assign commit = (state == ST_RUN) && (cnt == 4'd1);

  mdu_sequencer_arith u_arith (
    .op          (op_q),
    .rs          (rs_q),
    .rt          (rt_q),
    .hi          (hi),
    .lo          (lo),
    .hilo_nxt    (hilo_nxt),
    .div_by_zero (div_by_zero)
  );

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state: leave IDLE on a valid multi-cycle start, return on the final countdown edge.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (launch) state_nxt = ST_RUN;
      ST_RUN:  if (commit) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: busy tracks RUN; stall also covers the start cycle before busy rises.
  always_comb begin
    busy      = (state == ST_RUN);
    stall_req = d_mdu_use & (start | busy);
    rd_data   = 32'd0;
    if (mdu_op == OP_MFHI)      rd_data = hi;
    else if (mdu_op == OP_MFLO) rd_data = lo;
  end

  assign hi_out = hi;
  assign lo_out = lo;

  // Operand latch, countdown, and HI/LO writes (commit in RUN, mthi/mtlo only while IDLE).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= 4'd0;
      op_q <= 4'd0;
      rs_q <= 32'd0;
      rt_q <= 32'd0;
      hi   <= 32'd0;
      lo   <= 32'd0;
    end else begin
      if (launch) begin
        op_q <= mdu_op;
        rs_q <= rs_val;
        rt_q <= rt_val;
        cnt  <= is_div(mdu_op) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
      end else if (state == ST_RUN) begin
        cnt <= cnt - 4'd1;
      end

      if (commit) begin
        if (!div_by_zero) begin
          hi <= hilo_nxt[63:32];
          lo <= hilo_nxt[31:0];
        end
      end else if (state == ST_IDLE) begin
        if (mdu_op == OP_MTHI) hi <= rs_val;
        if (mdu_op == OP_MTLO) lo <= rs_val;
      end
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Randomized and directed bench for mdu_sequencer against an arithmetic reference model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// The model tracks HI/LO as plain integers and computes results with native SV arithmetic.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        d_mdu_use;
  logic        busy;
  logic        stall_req;
  logic [31:0] rd_data;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  always #5 clk = ~clk;

  mdu_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mdu_op    (mdu_op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .d_mdu_use (d_mdu_use),
    .busy      (busy),
    .stall_req (stall_req),
    .rd_data   (rd_data),
    .hi_out    (hi_out),
    .lo_out    (lo_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference {HI,LO} after the operation, from the current model HI/LO.
  function automatic logic [63:0] model_next(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int          sa;
    int          sb;
    longint      sp;
    longint      acc;
    logic [63:0] r;
    sa  = a;
    sb  = b;
    sp  = longint'(sa) * longint'(sb);
    acc = {m_hi, m_lo};
    r   = {m_hi, m_lo};
    case (op)
      4'd1:  r = sp;
      4'd2:  r = 64'(a) * 64'(b);
      4'd9:  r = acc + sp;
      4'd10: r = acc - sp;
      4'd3:  if (b != 0) r = {32'(sa % sb), 32'(sa / sb)};
      4'd4:  if (b != 0) r = {a % b, a / b};
      default: r = {m_hi, m_lo};
    endcase
    return r;
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_d, input logic poke);
    int          n;
    logic [63:0] exp;
    n   = (op == 4'd3 || op == 4'd4) ? 10 : 5;
    exp = model_next(op, a, b);
    start = 1'b1; mdu_op = op; rs_val = a; rt_val = b; d_mdu_use = use_d;
    #1;
    chk("start_busy", 64'(busy), 64'(1'b0));
    chk("start_stall", 64'(stall_req), 64'(use_d));
    @(negedge clk);
    start = 1'b0; mdu_op = 4'd0; rs_val = $urandom; rt_val = $urandom;
    for (int i = 0; i < n; i++) begin
      #1;
      chk("run_busy", 64'(busy), 64'(1'b1));
      chk("run_stall", 64'(stall_req), 64'(use_d));
      chk("run_hi_hold", 64'(hi_out), 64'(m_hi));
      chk("run_lo_hold", 64'(lo_out), 64'(m_lo));
      if (poke && i == 2) begin start = 1'b1; mdu_op = 4'd1; end
      if (poke && i == 3) begin mdu_op = 4'd7; rs_val = 32'hDEADBEEF; end
      @(negedge clk);
      start = 1'b0; mdu_op = 4'd0;
    end
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    #1;
    chk("end_busy", 64'(busy), 64'(1'b0));
    chk("end_stall", 64'(stall_req), 64'(1'b0));
    chk("end_hi", 64'(hi_out), 64'(m_hi));
    chk("end_lo", 64'(lo_out), 64'(m_lo));
    mdu_op = 4'd5; #1;
    chk("mfhi", 64'(rd_data), 64'(m_hi));
    mdu_op = 4'd6; #1;
    chk("mflo", 64'(rd_data), 64'(m_lo));
    mdu_op = 4'd0;
    @(negedge clk);
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] v);
    mdu_op = op; rs_val = v;
    @(negedge clk);
    mdu_op = 4'd0;
    if (op == 4'd7) m_hi = v;
    else            m_lo = v;
    #1;
    chk("mt_hi", 64'(hi_out), 64'(m_hi));
    chk("mt_lo", 64'(lo_out), 64'(m_lo));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] ops [8];
    logic [3:0] op;
    logic [31:0] a;
    logic [31:0] b;
    int t;
    ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd10, 4'd7, 4'd8};

    reset = 1'b1; start = 1'b0; mdu_op = 4'd0; rs_val = 32'd0; rt_val = 32'd0; d_mdu_use = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (2) @(negedge clk);
    mdu_op = 4'd5; #1;
    chk("rst_busy", 64'(busy), 64'(1'b0));
    chk("rst_stall", 64'(stall_req), 64'(1'b0));
    chk("rst_hi", 64'(hi_out), 64'(32'd0));
    chk("rst_lo", 64'(lo_out), 64'(32'd0));
    chk("rst_rd", 64'(rd_data), 64'(32'd0));
    mdu_op = 4'd0;
    @(negedge clk);
    reset = 1'b0; d_mdu_use = 1'b0;
    @(negedge clk);

    // Directed cases
    run_op(4'd1, 32'hFFFFFFFD, 32'd5, 1'b0, 1'b0);
    chk("tp_mult_hi", 64'(hi_out), 64'(32'hFFFFFFFF));
    chk("tp_mult_lo", 64'(lo_out), 64'(32'hFFFFFFF1));
    run_op(4'd2, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0);
    chk("tp_multu_hi", 64'(hi_out), 64'(32'h00000001));
    chk("tp_multu_lo", 64'(lo_out), 64'(32'hFFFFFFFE));
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0);
    chk("tp_div_hi", 64'(hi_out), 64'(32'hFFFFFFFF));
    chk("tp_div_lo", 64'(lo_out), 64'(32'hFFFFFFFD));
    run_op(4'd4, 32'd7, 32'd0, 1'b0, 1'b0);
    chk("tp_divz_hi", 64'(hi_out), 64'(32'hFFFFFFFF));
    chk("tp_divz_lo", 64'(lo_out), 64'(32'hFFFFFFFD));

    mt(4'd7, 32'h12345678);
    mt(4'd8, 32'h00000001);
    mdu_op = 4'd5; #1;
    chk("tp_mfhi_pre", 64'(rd_data), 64'(32'h12345678));
    mdu_op = 4'd6; #1;
    chk("tp_mflo_pre", 64'(rd_data), 64'(32'h00000001));
    mdu_op = 4'd0;
    @(negedge clk);
    run_op(4'd9, 32'd2, 32'd3, 1'b0, 1'b1);
    chk("tp_madd_hi", 64'(hi_out), 64'(32'h12345678));
    chk("tp_madd_lo", 64'(lo_out), 64'(32'h00000007));

    // Start with a non-sequenced opcode is not a launch
    start = 1'b1; mdu_op = 4'd6; d_mdu_use = 1'b1; #1;
    chk("ign_stall", 64'(stall_req), 64'(1'b1));
    @(negedge clk);
    start = 1'b0; mdu_op = 4'd0; #1;
    chk("ign_busy", 64'(busy), 64'(1'b0));
    chk("ign_stall_after", 64'(stall_req), 64'(1'b0));
    d_mdu_use = 1'b0;
    @(negedge clk);

    // Reset in the middle of a multiply
    mt(4'd7, 32'hA5A5A5A5);
    mt(4'd8, 32'h5A5A5A5A);
    start = 1'b1; mdu_op = 4'd1; rs_val = 32'd3; rt_val = 32'd4; d_mdu_use = 1'b1;
    @(negedge clk);
    start = 1'b0; mdu_op = 4'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("pre_rst_busy", 64'(busy), 64'(1'b1));
    #1 reset = 1'b1;
    #1;
    m_hi = 32'd0; m_lo = 32'd0;
    chk("midrst_busy", 64'(busy), 64'(1'b0));
    chk("midrst_stall", 64'(stall_req), 64'(1'b0));
    chk("midrst_hi", 64'(hi_out), 64'(m_hi));
    chk("midrst_lo", 64'(lo_out), 64'(m_lo));
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    chk("postrst_busy", 64'(busy), 64'(1'b0));
    chk("postrst_hi", 64'(hi_out), 64'(m_hi));
    chk("postrst_lo", 64'(lo_out), 64'(m_lo));
    d_mdu_use = 1'b0;
    @(negedge clk);

    // Randomized operations
    for (int k = 0; k < 40; k++) begin
      op = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 1) == 1) begin
        t = int'($urandom_range(0, 40)) - 20; a = t;
        t = int'($urandom_range(0, 40)) - 20; b = t;
      end else begin
        a = $urandom; b = $urandom;
      end
      if ($urandom_range(0, 5) == 0) b = 32'd0;
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
      if (op == 4'd7 || op == 4'd8) mt(op, a);
      else run_op(op, a, b, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle multiply/divide unit for the P6 five-stage MIPS pipeline.
- Lives in the E stage and is driven by the decoded MDU opcode and start strobe.
- Owns the HI/LO registers and sequences mult, div, madd and msub operations through a busy countdown.
- Produces the D-stage stall request that holds MDU-dependent instructions until the unit is free.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu/madd/msub (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  E-stage strobe; a multi-cycle MDU operation begins.
- mdu_op  input  4  E-stage opcode: 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 msub, 0 none.
- rs_val  input  32  forwarded rs operand.
- rt_val  input  32  forwarded rt operand.
- d_mdu_use  input  1  D-stage instruction has a nonzero MDU opcode.
- busy  output  1  operation in flight.
- stall_req  output  1  equals d_mdu_use & (start | busy).
- rd_data  output  32  HI when mdu_op=5, LO when mdu_op=6, else 0. Combinational from the committed registers.
- hi_out  output  32  current HI.
- lo_out  output  32  current LO.

Behaviour:
- Reset (async, any state, including mid-operation):
  - State IDLE; busy=0; counter=0; HI=0; LO=0; pending result=0.
  - Any in-flight result is discarded.
- States: IDLE, RUN.
- IDLE, start=1 with mdu_op in {1,2,3,4,9,10}:
  - Latch op, rs_val and rt_val.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN. busy=1 from the next cycle.
- IDLE, start=1 with any other mdu_op: ignored.
- RUN: counter decrements each cycle.
  - When counter==1, HI/LO commit on that edge, busy falls on the same edge, and the state returns to IDLE.
  - Observed latency: busy is high for exactly N cycles after the start cycle.
- Arithmetic (all 64-bit):
  - mult: {HI,LO} = signed rs * signed rt.
  - multu: unsigned product.
  - madd: {HI,LO} = {HI,LO} + signed product, computed at commit.
  - msub: {HI,LO} = {HI,LO} - signed product, wrap modulo 2^64.
  - div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Divide by zero (rt=0): HI and LO unchanged; busy still runs the full DIV_CYCLES.
- mthi/mtlo (op 7/8):
  - Write HI or LO from rs_val at the edge, in IDLE only.
  - In RUN they are ignored; stall_req keeps them out.
- start while RUN is ignored, and busy and the counter are unaffected. Pipeline stalls prevent this case; the rule covers robustness only.
- Simultaneous commit edge and a new start is impossible: start is only legal when busy=0.
- mfhi/mflo in the same cycle as a commit return the old value. Stall ordering guarantees they are not issued then.
- stall_req is asserted in the start cycle itself (start=1, busy still 0).

Decomposition:
- Shared header mdu_defs holds:
  - MDUOp codes 0-10 (identical to the decoder's encoding);
  - state encodings IDLE=0, RUN=1;
  - the default cycle counts.
- One sub-module, mdu_arith: combinational. It takes the latched op, operands and current HI/LO and returns the 64-bit next {HI,LO} plus a div_by_zero flag.
- The sequencer keeps the FSM, counter, registers and stall logic.

Test Plan:
- mult, rs=0xFFFFFFFD (-3), rt=5 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- multu, rs=0xFFFFFFFF, rt=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- div, rs=-7, rt=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 -> HI and LO unchanged after 10 cycles.
- mthi 0x12345678, mtlo 0x1 back to back, then madd rs=2, rt=3:
  - mfhi/mflo read 0x12345678 and 0x1 before the madd;
  - after 5 cycles LO=0x7, HI=0x12345678.
- start div with d_mdu_use=1 -> stall_req=1 in the start cycle and all 10 busy cycles, 0 the cycle after busy falls. With d_mdu_use=0 -> stall_req stays 0.
- reset pulsed at busy cycle 3 of a mult -> busy=0 and HI=LO=0 immediately. No later commit occurs.
